instr_fetch_unit: RTL and testbench

- Program counter and fetch stage sitting directly upstream of the synchronous instruction ROM (1-cycle read latency, 9-bit address, 32-bit word).
- Drives the ROM address and absorbs the read latency.
- Presents each fetched word, with its address, to decode through a valid/ready handshake.
- Supports branch/jump redirect from execute and stops fetching after a HALT opcode.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 tb/tb_instr_fetch_unit.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: opcode encodings,
// opcode field position and fetch state encoding.
package fetch_pkg;

   localparam int FETCH_DATA_WIDTH = 32;
   localparam int OPC_WIDTH        = 6;
   localparam int OPC_MSB          = FETCH_DATA_WIDTH - 1;
   localparam int OPC_LSB          = FETCH_DATA_WIDTH - OPC_WIDTH;

   localparam logic [OPC_WIDTH-1:0] OPC_NOP  = 6'b010000;
   localparam logic [OPC_WIDTH-1:0] OPC_HALT = 6'b010001;

   typedef enum logic [1:0] {
      S_PRIME = 2'd0,
      S_RUN   = 2'd1,
      S_HALT  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// PC register and fetch stage in front of a 1-cycle synchronous ROM.
// Build option FETCH_NOP_SKIP_EN: NOP words are dropped instead of issued.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
   parameter int RESET_PC   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_q,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  halted
);

   // Handshake: a word moves to decode on a rising edge where instr_valid and
   // instr_ready are both high; while valid && !ready, instr/instr_pc hold.

   fetch_state_e          state_q;
   logic [ADDR_WIDTH-1:0] fetch_pc_q;
   logic [ADDR_WIDTH-1:0] fetch_pc_d;
   logic [ADDR_WIDTH-1:0] last_addr_q;
   logic [DATA_WIDTH-1:0] instr_q;
   logic [ADDR_WIDTH-1:0] instr_pc_q;
   logic                  instr_valid_q;
   logic                  halted_q;
   logic                  advance;
   logic                  skip_word;
   logic [OPC_WIDTH-1:0]  opcode;

   assign advance    = !instr_valid_q || instr_ready;
   // On a stall the previous address is re-issued so rom_q keeps the word behind the pending one.
   assign rom_addr   = advance ? fetch_pc_q : last_addr_q;
   assign fetch_pc_d = fetch_pc_q + 1'b1;
   assign opcode     = rom_q[DATA_WIDTH-1 -: OPC_WIDTH];

`ifdef FETCH_NOP_SKIP_EN
   assign skip_word = (opcode == OPC_NOP);
`else
   assign skip_word = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_PRIME;
         fetch_pc_q    <= ADDR_WIDTH'(RESET_PC);
         last_addr_q   <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         last_addr_q <= rom_addr;
         if (redirect_valid) begin
            fetch_pc_q    <= redirect_pc;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            state_q       <= S_PRIME;
         end else begin
            case (state_q)
               S_PRIME: begin
                  fetch_pc_q <= fetch_pc_d;
                  state_q    <= S_RUN;
               end
               S_RUN: begin
                  if (advance) begin
                     fetch_pc_q <= fetch_pc_d;
                     // A skipped NOP leaves the contents alone; any word shown was just taken.
                     if (skip_word) begin
                        instr_valid_q <= 1'b0;
                     end else begin
                        instr_q       <= rom_q;
                        instr_pc_q    <= last_addr_q;
                        instr_valid_q <= 1'b1;
                        if (opcode == OPC_HALT) begin
                           state_q  <= S_HALT;
                           halted_q <= 1'b1;
                        end
                     end
                  end
               end
               S_HALT: begin
                  if (instr_ready) instr_valid_q <= 1'b0;
               end
               default: state_q <= S_PRIME;
            endcase
         end
      end
   end

   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: ROM model, scenario tasks and a program-walk reference model.
module tb_instr_fetch_unit;

   localparam int AW = 9;
   localparam int DW = 32;
   localparam logic [5:0] NOP_OPC  = 6'b010000;
   localparam logic [5:0] HALT_OPC = 6'b010001;
`ifdef FETCH_NOP_SKIP_EN
   localparam bit NOP_SKIP = 1'b1;
`else
   localparam bit NOP_SKIP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_q;
   logic [DW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          halted;

   logic [DW-1:0] rom [0:(1<<AW)-1];
   logic [AW-1:0] exp_pc_q[$];
   logic [DW-1:0] exp_q[$];

   int checks = 0;
   int errors = 0;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .rom_addr       (rom_addr),
      .rom_q          (rom_q),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_q <= rom[rom_addr];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] mk_word(input logic [5:0] opc);
      return {opc, 26'($urandom)};
   endfunction

   task automatic fill_rom(input int nop_pct, input int halt_pct);
      for (int i = 0; i < (1 << AW); i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < nop_pct) rom[i] = mk_word(NOP_OPC);
         else if (r < nop_pct + halt_pct) rom[i] = mk_word(HALT_OPC);
         else rom[i] = mk_word(6'($urandom_range(0, 15)));
      end
   endtask

   // Reference: the program is walked linearly from start; NOPs vanish when
   // skipping is built in, and nothing follows a HALT.
   task automatic build_exp(input logic [AW-1:0] start);
      logic [AW-1:0] pc;
      exp_pc_q.delete();
      exp_q.delete();
      pc = start;
      for (int n = 0; n < 1024; n++) begin
         if (!(NOP_SKIP && rom[pc][DW-1 -: 6] == NOP_OPC)) begin
            exp_pc_q.push_back(pc);
            exp_q.push_back(rom[pc]);
            if (rom[pc][DW-1 -: 6] == HALT_OPC) break;
         end
         pc = pc + 1'b1;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      instr_ready = 1'b0;
      redirect_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      fill_rom(0, 0);
      rst = 1'b1;
      instr_ready = 1'b1;
      redirect_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || halted !== 1'b0 || instr !== '0 || instr_pc !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b halted=%b instr=%h pc=%0d, want all zero",
                  instr_valid, halted, instr, instr_pc);
      end
      checks++;
      if (rom_addr !== AW'(1)) begin
         errors++;
         $display("FAIL reset_rom_addr: got %0d want 1", rom_addr);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || rom_addr !== AW'(2)) begin
         errors++;
         $display("FAIL prime_cycle: valid=%b rom_addr=%0d, want valid=0 rom_addr=2",
                  instr_valid, rom_addr);
      end
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== AW'(i) || instr !== rom[i] || rom_addr !== AW'(i + 2)) begin
            errors++;
            $display("FAIL first_issue_%0d: valid=%b pc=%0d instr=%h rom_addr=%0d, want 1/%0d/%h/%0d",
                     i, instr_valid, instr_pc, instr, rom_addr, i, rom[i], i + 2);
         end
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || instr_pc !== '0 || instr !== '0) begin
         errors++;
         $display("FAIL async_reset: valid=%b pc=%0d instr=%h, want all zero mid-cycle",
                  instr_valid, instr_pc, instr);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_stall();
      bit found = 1'b0;
      fill_rom(0, 0);
      apply_reset();
      instr_ready = 1'b1;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (instr_valid && instr_pc == AW'(3)) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL stall_reach_pc3: pc=%0d valid=%b, want pc 3 valid", instr_pc, instr_valid);
      end
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== AW'(3) || instr !== rom[3]) begin
            errors++;
            $display("FAIL stall_hold_%0d: valid=%b pc=%0d instr=%h, want 1/3/%h",
                     i, instr_valid, instr_pc, instr, rom[3]);
         end
      end
      instr_ready = 1'b1;
      for (int i = 4; i <= 5; i++) begin
         @(negedge clk);
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== AW'(i) || instr !== rom[i]) begin
            errors++;
            $display("FAIL stall_resume_%0d: valid=%b pc=%0d instr=%h, want 1/%0d/%h",
                     i, instr_valid, instr_pc, instr, i, rom[i]);
         end
      end
   endtask

   task automatic test_redirect();
      bit found = 1'b0;
      fill_rom(0, 0);
      apply_reset();
      instr_ready = 1'b1;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (instr_valid && instr_pc == AW'(7)) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL redirect_reach_pc7: pc=%0d valid=%b, want pc 7 valid", instr_pc, instr_valid);
      end
      redirect_valid = 1'b1;
      redirect_pc = AW'(31);
      @(negedge clk);
      redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_bubble_%0d: valid=%b want 0", i, instr_valid);
         end
      end
      for (int i = 31; i <= 32; i++) begin
         @(negedge clk);
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== AW'(i) || instr !== rom[i]) begin
            errors++;
            $display("FAIL redirect_target_%0d: valid=%b pc=%0d instr=%h, want 1/%0d/%h",
                     i, instr_valid, instr_pc, instr, i, rom[i]);
         end
      end
   endtask

   task automatic test_halt();
      int next_pc = 1;
      bit done = 1'b0;
      fill_rom(0, 0);
      rom[10] = mk_word(HALT_OPC);
      apply_reset();
      instr_ready = 1'b1;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         if (instr_valid) begin
            checks++;
            if (instr_pc !== AW'(next_pc) || instr !== rom[next_pc]) begin
               errors++;
               $display("FAIL halt_seq: pc=%0d instr=%h, want %0d/%h", instr_pc, instr, next_pc, rom[next_pc]);
            end
            if (instr_pc == AW'(10)) done = 1'b1;
            next_pc++;
         end
      end
      checks++;
      if (!done || halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_flag: seen_pc10=%b halted=%b, want 1/1", done, halted);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (instr_valid !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_idle_%0d: valid=%b halted=%b, want 0/1", i, instr_valid, halted);
         end
      end
      redirect_valid = 1'b1;
      redirect_pc = AW'(32);
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++;
      if (halted !== 1'b0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_clear: halted=%b valid=%b, want 0/0", halted, instr_valid);
      end
      @(negedge clk);
      for (int i = 32; i <= 33; i++) begin
         @(negedge clk);
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== AW'(i) || instr !== rom[i]) begin
            errors++;
            $display("FAIL halt_resume_%0d: valid=%b pc=%0d instr=%h, want 1/%0d/%h",
                     i, instr_valid, instr_pc, instr, i, rom[i]);
         end
      end
   endtask

   task automatic test_wrap();
      bit found = 1'b0;
      fill_rom(0, 0);
      apply_reset();
      instr_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = AW'(511);
      @(negedge clk);
      redirect_valid = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (instr_valid) found = 1'b1;
      end
      checks++;
      if (!found || instr_pc !== AW'(511) || instr !== rom[511]) begin
         errors++;
         $display("FAIL wrap_511: valid=%b pc=%0d instr=%h, want 1/511/%h", instr_valid, instr_pc, instr, rom[511]);
      end
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(0) || instr !== rom[0]) begin
         errors++;
         $display("FAIL wrap_0: valid=%b pc=%0d instr=%h, want 1/0/%h", instr_valid, instr_pc, instr, rom[0]);
      end
   endtask

   task automatic test_nop();
      int got = 0;
      fill_rom(0, 0);
      rom[4] = mk_word(NOP_OPC);
      rom[5] = mk_word(NOP_OPC);
      build_exp(AW'(1));
      apply_reset();
      instr_ready = 1'b1;
      for (int i = 0; i < 30 && got < 5; i++) begin
         @(negedge clk);
         if (instr_valid) begin
            checks++;
            if (instr_pc !== exp_pc_q[0] || instr !== exp_q[0]) begin
               errors++;
               $display("FAIL nop_seq_%0d: pc=%0d instr=%h, want %0d/%h", got, instr_pc, instr, exp_pc_q[0], exp_q[0]);
            end
            void'(exp_pc_q.pop_front());
            void'(exp_q.pop_front());
            got++;
         end
      end
      checks++;
      if (got != 5) begin
         errors++;
         $display("FAIL nop_count: issued %0d want 5", got);
      end
   endtask

   task automatic test_random();
      int transfers = 0;
      bit hold = 1'b0;
      logic [DW-1:0] hold_instr;
      logic [AW-1:0] hold_pc;
      fill_rom(10, 3);
      apply_reset();
      build_exp(AW'(1));
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         if (hold) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== hold_instr || instr_pc !== hold_pc) begin
               errors++;
               $display("FAIL rand_stable: valid=%b pc=%0d instr=%h, want 1/%0d/%h",
                        instr_valid, instr_pc, instr, hold_pc, hold_instr);
            end
         end
         redirect_valid = ($urandom_range(0, 99) < 2);
         instr_ready = ($urandom_range(0, 3) != 0);
         if (redirect_valid) begin
            redirect_pc = AW'($urandom);
            build_exp(redirect_pc);
            hold = 1'b0;
         end else begin
            hold = instr_valid && !instr_ready;
            hold_instr = instr;
            hold_pc = instr_pc;
            if (instr_valid && instr_ready) begin
               checks++;
               if (exp_pc_q.size() == 0) begin
                  errors++;
                  $display("FAIL rand_extra: pc=%0d instr=%h, want no transfer", instr_pc, instr);
               end else begin
                  if (instr_pc !== exp_pc_q[0] || instr !== exp_q[0]) begin
                     errors++;
                     $display("FAIL rand_xfer: pc=%0d instr=%h, want %0d/%h", instr_pc, instr, exp_pc_q[0], exp_q[0]);
                  end
                  void'(exp_pc_q.pop_front());
                  void'(exp_q.pop_front());
               end
               transfers++;
            end
         end
      end
      redirect_valid = 1'b0;
      checks++;
      if (transfers < 100) begin
         errors++;
         $display("FAIL rand_throughput: %0d transfers, want at least 100", transfers);
      end
   endtask

   initial begin
      test_reset();
      test_stall();
      test_redirect();
      test_halt();
      test_wrap();
      test_nop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
